// File: rtl/hilo_muldiv_seq.sv
// Sequential HI/LO multiply/divide unit: 32-step shift-add multiply and
// restoring divide behind a start/busy/done handshake, plus MTHI/MTLO writes.
module hilo_muldiv_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] outHI,
   output logic [31:0] outLO,
   output logic        busy,
   output logic        done,
   output logic        divZero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_busy;
   logic        r_done;
   logic        r_div_zero;
   logic [4:0]  r_cnt;

   logic [31:0] r_acc_hi;
   logic [31:0] r_acc_lo;
   logic [31:0] r_opnd;
   logic [31:0] r_a_orig;
   logic        r_is_div;
   logic        r_neg_res;
   logic        r_neg_rem;
   logic        r_b_zero;

   logic        w_start_arith;
   logic        w_start_mt;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;

   logic [32:0] w_mul_add;
   logic [32:0] w_div_shift;
   logic [32:0] w_div_trial;
   logic [31:0] w_step_hi;
   logic [31:0] w_step_lo;

   logic [63:0] w_prod;
   logic [63:0] w_prod_fix;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;
   logic [31:0] w_fix_hi;
   logic [31:0] w_fix_lo;

   function automatic logic [31:0] f_cond_neg32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] f_cond_neg64(input logic [63:0] v, input logic neg);
      return neg ? (~v + 64'd1) : v;
   endfunction

   assign outHI   = r_hi;
   assign outLO   = r_lo;
   assign busy    = r_busy;
   assign done    = r_done;
   assign divZero = r_div_zero;

   // Issue decode; ops 000 and 010 are the signed ones
   assign w_start_arith = (r_state == S_IDLE) && start && !op[2];
   assign w_start_mt    = (r_state == S_IDLE) && start && (op == OP_MTHI || op == OP_MTLO);
   assign w_a_neg       = !op[0] && A[31];
   assign w_b_neg       = !op[0] && B[31];
   assign w_a_mag       = f_cond_neg32(A, w_a_neg);
   assign w_b_mag       = f_cond_neg32(B, w_b_neg);

   // One iteration: multiply adds then shifts right, divide shifts left then trial-subtracts
   assign w_mul_add   = r_acc_lo[0] ? ({1'b0, r_acc_hi} + {1'b0, r_opnd}) : {1'b0, r_acc_hi};
   assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
   assign w_div_trial = w_div_shift - {1'b0, r_opnd};

   always_comb begin
      w_step_hi = w_mul_add[32:1];
      w_step_lo = {w_mul_add[0], r_acc_lo[31:1]};
      if (r_is_div) begin
         w_step_hi = w_div_trial[32] ? w_div_shift[31:0] : w_div_trial[31:0];
         w_step_lo = {r_acc_lo[30:0], ~w_div_trial[32]};
      end
   end

   // Sign fix-up and divide-by-zero override applied at the FIX edge
   assign w_prod     = {r_acc_hi, r_acc_lo};
   assign w_prod_fix = f_cond_neg64(w_prod, r_neg_res);
   assign w_quo_fix  = f_cond_neg32(r_acc_lo, r_neg_res);
   assign w_rem_fix  = f_cond_neg32(r_acc_hi, r_neg_rem);

   always_comb begin
      w_fix_hi = w_prod_fix[63:32];
      w_fix_lo = w_prod_fix[31:0];
      if (r_is_div && r_b_zero) begin
         w_fix_hi = r_a_orig;
         w_fix_lo = 32'hFFFF_FFFF;
      end else if (r_is_div) begin
         w_fix_hi = w_rem_fix;
         w_fix_lo = w_quo_fix;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_arith) w_state_nxt = S_RUN;
         S_RUN:   if (r_cnt == 5'd31) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_cnt      <= 5'd0;
         r_acc_hi   <= 32'd0;
         r_acc_lo   <= 32'd0;
         r_opnd     <= 32'd0;
         r_a_orig   <= 32'd0;
         r_is_div   <= 1'b0;
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_b_zero   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_arith) begin
                  r_busy     <= 1'b1;
                  r_div_zero <= 1'b0;
                  r_cnt      <= 5'd0;
                  r_acc_hi   <= 32'd0;
                  r_acc_lo   <= op[1] ? w_a_mag : w_b_mag;
                  r_opnd     <= op[1] ? w_b_mag : w_a_mag;
                  r_a_orig   <= A;
                  r_is_div   <= op[1];
                  r_neg_res  <= w_a_neg ^ w_b_neg;
                  r_neg_rem  <= w_a_neg;
                  r_b_zero   <= (B == 32'd0);
               end else if (w_start_mt) begin
                  r_div_zero <= 1'b0;
                  if (op == OP_MTHI) begin
                     r_hi <= A;
                  end else begin
                     r_lo <= A;
                  end
               end
            end
            S_RUN: begin
               r_acc_hi <= w_step_hi;
               r_acc_lo <= w_step_lo;
               r_cnt    <= r_cnt + 5'd1;
            end
            S_FIX: begin
               r_hi       <= w_fix_hi;
               r_lo       <= w_fix_lo;
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
               r_div_zero <= r_is_div && r_b_zero;
            end
            default: r_busy <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Scoreboard bench for hilo_muldiv_seq: expected HI/LO/divZero pushed at issue,
// popped and compared by a monitor whenever done pulses.
module tb_hilo_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] outHI;
   logic [31:0] outLO;
   logic        busy;
   logic        done;
   logic        divZero;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0;
   bit   chk_width = 1'b0;

   localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
   localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101;

   hilo_muldiv_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .outHI(outHI), .outLO(outLO), .busy(busy), .done(done), .divZero(divZero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per done pulse
   always @(negedge clk) begin
      if (chk_width) begin
         check("done_width", {31'd0, done}, 32'd0);
         chk_width = 1'b0;
      end
      if (done) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done (HI=%h LO=%h)", outHI, outLO);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("outHI", outHI, e.hi);
            check("outLO", outLO, e.lo);
            check("divZero", {31'd0, divZero}, {31'd0, e.dz});
            check("busy_cycles", busy_cnt, 32'd33);
         end
         chk_width = 1'b1;
         busy_cnt  = 0;
      end else if (busy) begin
         busy_cnt++;
      end else begin
         busy_cnt = 0;
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no done within 100 cycles expected done");
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input logic dz);
      exp_t e;
      e.hi = hi;
      e.lo = lo;
      e.dz = dz;
      sb_q.push_back(e);
      issue(o, a, b);
      wait_done();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 3'b111;
      A     = 32'd0;
      B     = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_outHI", outHI, 32'd0);
      check("rst_outLO", outLO, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_divZero", {31'd0, divZero}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      // back-to-back: issued in the done cycle
      run_op(MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op(DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      run_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
      run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
      run_op(DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
      run_op(DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1);

      @(negedge clk);
      check("dz_held", {31'd0, divZero}, 32'd1);
      issue(MTLO, 32'h0000_0055, 32'd0);
      check("mtlo_outLO", outLO, 32'h0000_0055);
      check("mtlo_dz_clr", {31'd0, divZero}, 32'd0);
      check("mtlo_done", {31'd0, done}, 32'd0);
      issue(MTHI, 32'h0000_1234, 32'd0);
      check("mthi_outHI", outHI, 32'h0000_1234);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      check("mthi_done", {31'd0, done}, 32'd0);

      begin
         exp_t e;
         e.hi = 32'd0;
         e.lo = 32'd30;
         e.dz = 1'b0;
         sb_q.push_back(e);
      end
      issue(MULTU, 32'd5, 32'd6);
      repeat (8) @(negedge clk);
      start = 1'b1;
      op    = MTLO;
      A     = 32'h0000_DEAD;
      @(negedge clk);
      op    = MULTU;
      A     = 32'd7;
      B     = 32'd7;
      @(negedge clk);
      start = 1'b0;
      check("run_hold_LO", outLO, 32'h0000_0055);
      check("run_hold_HI", outHI, 32'h0000_1234);
      wait_done();
      repeat (40) @(negedge clk);

      issue(MULTU, 32'd5, 32'd6);
      repeat (13) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_outHI", outHI, 32'd0);
      check("abort_outLO", outLO, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (40) @(negedge clk);

      run_op(DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
